// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM states,
// iteration-count width and the divide-by-zero quotient pattern.
package div_pkg;

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    // Sliced down to the operand width where used.
    localparam logic [63:0] DZ_QUOT = '1;

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/divider_addsub_stage.sv
// Parameterised W-bit adder/subtractor used for the divider's trial subtraction.
// neg is the sign bit of the result, which doubles as the borrow indicator.
module divider_addsub_stage #(
    parameter int W = 9
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic [W-1:0] sum,
    output logic         neg
);

    logic [W-1:0] b_op;

    assign b_op = sub ? ~b : b;
    assign sum  = a + b_op + W'(sub);
    assign neg  = sum[W-1];

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring divider, one quotient bit per clock, truncating semantics.
// Define DIVIDER_SIGNED_EN for two's-complement operands; otherwise operands are unsigned.
module seq_divider
    import div_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         dz,
    output logic         ovf
);

    localparam int CW = cnt_w(N);

    state_t        state, state_nx;
    logic [CW-1:0] cnt;
    logic [N:0]    rem;
    logic [N-1:0]  quo;
    logic [N-1:0]  dmag;
    logic          q_neg, r_neg;

    logic          dvd_sign, dvs_sign;
    logic [N-1:0]  dvd_mag, dvs_mag;
    logic          is_zero, is_ovf, accept, last;
    logic [N:0]    rem_sh, trial, rem_nx;
    logic          trial_neg;
    logic [N-1:0]  quo_nx;

    function automatic logic [N-1:0] neg_if(input logic s, input logic [N-1:0] v);
        return s ? (~v + N'(1)) : v;
    endfunction

`ifdef DIVIDER_SIGNED_EN
    assign dvd_sign = dividend[N-1];
    assign dvs_sign = divisor[N-1];
    assign is_ovf   = (dividend == {1'b1, {(N-1){1'b0}}}) && (divisor == '1);
`else
    assign dvd_sign = 1'b0;
    assign dvs_sign = 1'b0;
    assign is_ovf   = 1'b0;
`endif

    assign dvd_mag = neg_if(dvd_sign, dividend);
    assign dvs_mag = neg_if(dvs_sign, divisor);
    assign is_zero = (divisor == '0);
    assign accept  = (state == IDLE) && start;
    assign last    = (cnt == CW'(1));

    // {rem, quo} shifts left; the dividend bits leave quo as quotient bits enter.
    assign rem_sh = (rem << 1) | {{N{1'b0}}, quo[N-1]};

    divider_addsub_stage #(.W(N + 1)) u_trial (
        .a   (rem_sh),
        .b   ({1'b0, dmag}),
        .sub (1'b1),
        .sum (trial),
        .neg (trial_neg)
    );

    assign rem_nx = trial_neg ? rem_sh : trial;
    assign quo_nx = {quo[N-2:0], ~trial_neg};

    assign busy = (state == CALC);
    assign done = (state == FIN);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start) state_nx = (is_zero || is_ovf) ? FIN : CALC;
            CALC: if (last) state_nx = FIN;
            FIN:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            dz        <= 1'b0;
            ovf       <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else if (accept) begin
            cnt <= CW'(N);
            dz  <= is_zero;
            ovf <= is_ovf;
            if (is_zero) begin
                quotient  <= DZ_QUOT[N-1:0];
                remainder <= dividend;
            end else if (is_ovf) begin
                quotient  <= {1'b1, {(N-1){1'b0}}};
                remainder <= '0;
            end
        end else if (state == CALC) begin
            cnt <= cnt - CW'(1);
            // Sign fix applied on the final iteration so results are valid with done.
            if (last) begin
                quotient  <= neg_if(q_neg, quo_nx);
                remainder <= neg_if(r_neg, rem_nx[N-1:0]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            rem   <= '0;
            quo   <= dvd_mag;
            dmag  <= dvs_mag;
            q_neg <= dvd_sign ^ dvs_sign;
            r_neg <= dvd_sign;
        end else if (state == CALC) begin
            rem <= rem_nx;
            quo <= quo_nx;
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider (N=8); expectations follow DIVIDER_SIGNED_EN.
module tb_seq_divider;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst, start;
    logic [N-1:0] dividend, divisor;
    logic         busy, done, dz, ovf;
    logic [N-1:0] quotient, remainder;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
        logic       ovf;
        int         lat;
    } exp_t;

    exp_t sb[$];

    seq_divider #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .dz        (dz),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        int   sa, sb_, q, r;
        e.dz  = 1'b0;
        e.ovf = 1'b0;
        e.lat = N + 1;
`ifdef DIVIDER_SIGNED_EN
        sa  = int'($signed(a));
        sb_ = int'($signed(b));
`else
        sa  = int'(a);
        sb_ = int'(b);
`endif
        if (sb_ == 0) begin
            e.q = 8'hFF; e.r = a; e.dz = 1'b1; e.lat = 1;
        end
`ifdef DIVIDER_SIGNED_EN
        else if (sa == -128 && sb_ == -1) begin
            e.q = 8'h80; e.r = 8'h00; e.ovf = 1'b1; e.lat = 1;
        end
`endif
        else begin
            q = sa / sb_;
            r = sa % sb_;
            e.q = q[7:0];
            e.r = r[7:0];
        end
        return e;
    endfunction

    // Drives one division from an idle DUT and compares on done; optionally
    // re-pulses start with other operands while the division is running.
    task automatic run_div(input logic [7:0] a, input logic [7:0] b, input bit repulse);
        int   cyc;
        bit   seen;
        exp_t e;
        @(negedge clk);
        start = 1'b1; dividend = a; divisor = b;
        sb.push_back(model(a, b));
        cyc = 0; seen = 0;
        while (!seen && cyc < 40) begin
            @(posedge clk);
            cyc++;
            #1;
            start = repulse && (cyc == 3);
            if (start) begin dividend = 8'd99; divisor = 8'd5; end
            @(negedge clk);
            if (done) seen = 1;
        end
        e = sb.pop_front();
        if (!seen) begin
            check("done_timeout", 0, 1);
        end else begin
            check("latency", cyc, e.lat);
            check("quotient", quotient, e.q);
            check("remainder", remainder, e.r);
            check("dz", dz, e.dz);
            check("ovf", ovf, e.ovf);
            check("busy_at_done", busy, 0);
        end
        start = 1'b0;
    endtask

    initial begin
        bit seen;
        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        check("rst_dz", dz, 0);
        check("rst_ovf", ovf, 0);
        rst = 1'b0;

        run_div(8'd100, 8'd7, 0);
        run_div(8'h9C, 8'h07, 0);
        run_div(8'd100, 8'hF9, 0);
        run_div(8'd5, 8'd0, 0);
        run_div(8'd9, 8'd3, 0);
        run_div(8'h80, 8'hFF, 0);
        run_div(8'h80, 8'h01, 0);
        run_div(8'h7F, 8'hFF, 0);
        run_div(8'h80, 8'h80, 0);
        run_div(8'hC8, 8'h07, 0);

        // start held during FIN must be ignored
        start = 1'b1; dividend = 8'd9; divisor = 8'd3;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("fin_start_busy", busy, 0);
        @(negedge clk);
        check("fin_start_busy2", busy, 0);
        check("fin_start_done", done, 0);

        run_div(8'd50, 8'd3, 1);

        // reset in the middle of a calculation
        @(negedge clk);
        start = 1'b1; dividend = 8'd50; divisor = 8'd3;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_quotient", quotient, 0);
        check("abort_remainder", remainder, 0);
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        check("abort_no_done", seen, 0);

        for (int i = 0; i < 16; i++) begin
            logic [7:0] a, b;
            a = 8'($urandom_range(0, 255));
            b = (i % 5 == 0) ? 8'd0 : 8'($urandom_range(0, 255));
            run_div(a, b, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
